// File: rtl/drop_merge_core_p.sv
// Drop-and-merge puzzle core: owns the tile grid, spawns random tiles, steers the
// drop cursor and runs the land / merge / gravity cascade for each dropped tile.
module drop_merge_core_p #(
    parameter int          ROWS          = 4,
    parameter int          COLS          = 4,
    parameter int          VAL_W         = 5,
    parameter int          SCORE_W       = 16,
    parameter int          WIN_POW       = 11,
    parameter int          OVERFLOW_MODE = 0,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_left,
    input  logic                       cmd_right,
    input  logic                       cmd_drop,
    output logic [ROWS*COLS*VAL_W-1:0] board_flat,
    output logic [SCORE_W-1:0]         score,
    output logic [$clog2(COLS)-1:0]    cursor_col,
    output logic [VAL_W-1:0]           spawn_val,
    output logic                       busy,
    output logic                       game_over,
    output logic                       game_won,
    output logic                       drop_rejected
);
    localparam int CW = $clog2(COLS);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [VAL_W-1:0] PMAX = '1;

    localparam logic [2:0] S_SPAWN = 3'd0;
    localparam logic [2:0] S_INPUT = 3'd1;
    localparam logic [2:0] S_LAND  = 3'd2;
    localparam logic [2:0] S_MERGE = 3'd3;
    localparam logic [2:0] S_GRAV  = 3'd4;
    localparam logic [2:0] S_END   = 3'd5;

    typedef logic [ROWS-1:0][COLS-1:0][VAL_W-1:0] grid_t;

    logic [2:0]         state_q, state_d;
    grid_t              grid_q, grid_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [CW-1:0]      cursor_q, cursor_d;
    logic [VAL_W-1:0]   spawn_q, spawn_d;
    logic               over_q, over_d, won_q, won_d, rej_q, rej_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [CW-1:0]      col_q, col_d, gcol_q, gcol_d;
    logic [RW-1:0]      row_q, row_d;
    logic [VAL_W-1:0]   val_q, val_d;

    logic [VAL_W-1:0]   cur_v, nxt_v, below_v, left_v, right_v, max_v;
    logic               can_merge, merge_hit, top_found;
    logic [RW-1:0]      top_row;
    logic [VAL_W+1:0]   pick;

    // Adds 2^p to the score, pinning at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] add_pow(input logic [SCORE_W-1:0] s,
                                                   input logic [VAL_W-1:0] p);
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + ((SCORE_W+1)'(1) << p);
        if (int'(p) >= SCORE_W || sum[SCORE_W]) return '1;
        return sum[SCORE_W-1:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        grid_d   = grid_q;
        score_d  = score_q;
        cursor_d = cursor_q;
        spawn_d  = spawn_q;
        over_d   = over_q;
        won_d    = won_q;
        rej_d    = 1'b0;
        col_d    = col_q;
        gcol_d   = gcol_q;
        row_d    = row_q;
        val_d    = val_q;
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        // Out-of-grid neighbours read as 0, which never equals an occupied cell.
        cur_v     = grid_q[row_q][col_q];
        nxt_v     = cur_v + 1'b1;
        can_merge = (cur_v != PMAX);
        below_v   = (row_q != RW'(ROWS-1)) ? grid_q[row_q + 1'b1][col_q] : '0;
        left_v    = (col_q != '0) ? grid_q[row_q][col_q - 1'b1] : '0;
        right_v   = (col_q != CW'(COLS-1)) ? grid_q[row_q][col_q + 1'b1] : '0;
        merge_hit = can_merge && (below_v == cur_v || left_v == cur_v || right_v == cur_v);

        top_found = 1'b0;
        top_row   = '0;
        for (int r = ROWS-1; r >= 0; r--) begin
            if (grid_q[r][col_q] != '0) begin
                top_found = 1'b1;
                top_row   = RW'(r);
            end
        end

        max_v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (grid_q[r][c] > max_v) max_v = grid_q[r][c];
        pick = ({2'b00, max_v} < (VAL_W+2)'(4)) ? (VAL_W+2)'(1) : {2'b00, max_v} - (VAL_W+2)'(3);
        if (lfsr_q[2:0] == 3'd7)       pick = pick + (VAL_W+2)'(2);
        else if (lfsr_q[2:0] >= 3'd5)  pick = pick + (VAL_W+2)'(1);

        case (state_q)
            S_SPAWN: begin
                spawn_d  = (pick > {2'b00, PMAX}) ? PMAX : pick[VAL_W-1:0];
                cursor_d = CW'(COLS/2);
                state_d  = S_INPUT;
            end
            S_INPUT: begin
                if (cmd_drop) begin
                    val_d   = spawn_q;
                    col_d   = cursor_q;
                    state_d = S_LAND;
                end else if (cmd_left && !cmd_right) begin
                    if (cursor_q != '0) cursor_d = cursor_q - 1'b1;
                end else if (cmd_right && !cmd_left) begin
                    if (cursor_q != CW'(COLS-1)) cursor_d = cursor_q + 1'b1;
                end
            end
            S_LAND: begin
                if (!top_found) begin
                    grid_d[ROWS-1][col_q] = val_q;
                    row_d   = RW'(ROWS-1);
                    state_d = S_MERGE;
                end else if (top_row != '0) begin
                    grid_d[top_row - 1'b1][col_q] = val_q;
                    row_d   = top_row - 1'b1;
                    state_d = S_MERGE;
                end else if (grid_q[0][col_q] == val_q && val_q != PMAX) begin
                    // Full column whose top matches: absorb into the top tile.
                    grid_d[0][col_q] = val_q + 1'b1;
                    score_d = add_pow(score_q, val_q + 1'b1);
                    if (int'(val_q) + 1 == WIN_POW) won_d = 1'b1;
                    row_d   = '0;
                    state_d = S_MERGE;
                end else if (OVERFLOW_MODE == 0) begin
                    over_d  = 1'b1;
                    state_d = S_END;
                end else begin
                    rej_d   = 1'b1;
                    state_d = S_INPUT;
                end
            end
            S_MERGE: begin
                if (can_merge && below_v == cur_v) begin
                    grid_d[row_q][col_q]        = '0;
                    grid_d[row_q + 1'b1][col_q] = nxt_v;
                    row_d = row_q + 1'b1;
                end else if (can_merge && left_v == cur_v) begin
                    grid_d[row_q][col_q - 1'b1] = '0;
                    grid_d[row_q][col_q]        = nxt_v;
                    gcol_d  = col_q - 1'b1;
                    state_d = S_GRAV;
                end else if (can_merge && right_v == cur_v) begin
                    grid_d[row_q][col_q + 1'b1] = '0;
                    grid_d[row_q][col_q]        = nxt_v;
                    gcol_d  = col_q + 1'b1;
                    state_d = S_GRAV;
                end else begin
                    state_d = won_q ? S_END : S_SPAWN;
                end
                if (merge_hit) begin
                    score_d = add_pow(score_q, nxt_v);
                    if (int'(nxt_v) == WIN_POW) won_d = 1'b1;
                end
            end
            S_GRAV: begin
                // Close the hole at row_q in the neighbour column; fallers are not re-checked.
                for (int r = ROWS-1; r > 0; r--)
                    if (RW'(r) <= row_q) grid_d[r][gcol_q] = grid_q[r-1][gcol_q];
                grid_d[0][gcol_q] = '0;
                state_d = S_MERGE;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_SPAWN;
            grid_q   <= '0;
            score_q  <= '0;
            cursor_q <= CW'(COLS/2);
            spawn_q  <= '0;
            over_q   <= 1'b0;
            won_q    <= 1'b0;
            rej_q    <= 1'b0;
            lfsr_q   <= LFSR_SEED;
            col_q    <= '0;
            gcol_q   <= '0;
            row_q    <= '0;
            val_q    <= '0;
        end else begin
            state_q  <= state_d;
            grid_q   <= grid_d;
            score_q  <= score_d;
            cursor_q <= cursor_d;
            spawn_q  <= spawn_d;
            over_q   <= over_d;
            won_q    <= won_d;
            rej_q    <= rej_d;
            lfsr_q   <= lfsr_d;
            col_q    <= col_d;
            gcol_q   <= gcol_d;
            row_q    <= row_d;
            val_q    <= val_d;
        end
    end

    assign board_flat    = grid_q;
    assign score         = score_q;
    assign cursor_col    = cursor_q;
    assign spawn_val     = spawn_q;
    assign busy          = (state_q != S_INPUT);
    assign game_over     = over_q;
    assign game_won      = won_q;
    assign drop_rejected = rej_q;
endmodule

// File: tb/tb_drop_merge_core_p.sv
// Random play against two cores (game-over and reject overflow modes) checked every
// cycle against a cascade model that precomputes the per-cycle board sequence.
module tb_drop_merge_core_p;
    localparam int R = 4, C = 4, VW = 3, SW = 8, PM = 7, NB = R*C*VW;
    localparam int SMAX = (1 << SW) - 1;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0, rst = 1'b1, cmd_left = 1'b0, cmd_right = 1'b0, cmd_drop = 1'b0;
    logic [NB-1:0] bd [2];
    logic [SW-1:0] sco [2];
    logic [1:0]    cur [2];
    logic [VW-1:0] spw [2];
    logic          bsy [2], ovr [2], wn [2], rej [2];

    always #5 clk = ~clk;

    drop_merge_core_p #(.ROWS(R), .COLS(C), .VAL_W(VW), .SCORE_W(SW), .WIN_POW(6),
                        .OVERFLOW_MODE(0), .LFSR_SEED(SEED)) u0 (
        .clk(clk), .rst(rst), .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_drop(cmd_drop),
        .board_flat(bd[0]), .score(sco[0]), .cursor_col(cur[0]), .spawn_val(spw[0]),
        .busy(bsy[0]), .game_over(ovr[0]), .game_won(wn[0]), .drop_rejected(rej[0]));

    drop_merge_core_p #(.ROWS(R), .COLS(C), .VAL_W(VW), .SCORE_W(SW), .WIN_POW(8),
                        .OVERFLOW_MODE(1), .LFSR_SEED(SEED)) u1 (
        .clk(clk), .rst(rst), .cmd_left(cmd_left), .cmd_right(cmd_right), .cmd_drop(cmd_drop),
        .board_flat(bd[1]), .score(sco[1]), .cursor_col(cur[1]), .spawn_val(spw[1]),
        .busy(bsy[1]), .game_over(ovr[1]), .game_won(wn[1]), .drop_rejected(rej[1]));

    typedef struct {
        logic [NB-1:0] board;
        int score;
        int cur;
        int spw;
        bit busy;
        bit over;
        bit won;
        bit rej;
        bit is_spawn;
    } snap_t;

    snap_t ex [2];
    snap_t q0 [$];
    snap_t q1 [$];
    snap_t bs;
    int g [R][C];
    int winp [2] = '{6, 8};
    int ovm [2] = '{0, 1};
    logic [15:0] lf;
    int checks = 0, errors = 0;

    task automatic qpush(input int k, input snap_t s);
        if (k == 0) q0.push_back(s); else q1.push_back(s);
    endtask
    task automatic qpop(input int k, output snap_t s);
        if (k == 0) s = q0.pop_front(); else s = q1.pop_front();
    endtask
    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [NB-1:0] pack_g();
        logic [NB-1:0] b = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) b[(r*C+c)*VW +: VW] = VW'(g[r][c]);
        return b;
    endfunction
    task automatic unpack_g(input logic [NB-1:0] b);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) g[r][c] = int'(b[(r*C+c)*VW +: VW]);
    endtask

    function automatic int spawn_of(input logic [NB-1:0] b, input logic [15:0] l);
        int mx = 0, base, v;
        for (int i = 0; i < R*C; i++)
            if (int'(b[i*VW +: VW]) > mx) mx = int'(b[i*VW +: VW]);
        base = (mx < 4) ? 1 : mx - 3;
        case (l[2:0])
            3'd5, 3'd6: v = base + 1;
            3'd7:       v = base + 2;
            default:    v = base;
        endcase
        return (v > PM) ? PM : v;
    endfunction

    task automatic scored(input int k, input int p);
        bs.score = bs.score + (1 << p);
        if (bs.score > SMAX) bs.score = SMAX;
        if (p == winp[k]) bs.won = 1'b1;
    endtask
    task automatic emit(input int k);
        bs.board = pack_g();
        qpush(k, bs);
    endtask
    task automatic fall(input int col, input int row);
        for (int r = row; r > 0; r--) g[r][col] = g[r-1][col];
        g[0][col] = 0;
    endtask

    // Whole cascade for one drop, one queued snapshot per clock after the drop edge.
    task automatic build(input int k);
        int c, v, t, r, val;
        bit done;
        bs = ex[k];
        bs.is_spawn = 1'b0;
        unpack_g(bs.board);
        c = bs.cur; v = bs.spw; t = -1; r = 0;
        for (int i = R-1; i >= 0; i--) if (g[i][c] != 0) t = i;
        if (t < 0) begin g[R-1][c] = v; r = R-1; end
        else if (t > 0) begin g[t-1][c] = v; r = t-1; end
        else if (g[0][c] == v && v < PM) begin g[0][c] = v + 1; scored(k, v + 1); r = 0; end
        else begin
            if (ovm[k] == 0) bs.over = 1'b1;
            else begin bs.busy = 1'b0; bs.rej = 1'b1; end
            emit(k);
            return;
        end
        emit(k);
        done = 1'b0;
        while (!done) begin
            val = g[r][c];
            if (val < PM && r < R-1 && g[r+1][c] == val) begin
                g[r][c] = 0; g[r+1][c] = val + 1; scored(k, val + 1); r++; emit(k);
            end else if (val < PM && c > 0 && g[r][c-1] == val) begin
                g[r][c-1] = 0; g[r][c] = val + 1; scored(k, val + 1); emit(k);
                fall(c-1, r); emit(k);
            end else if (val < PM && c < C-1 && g[r][c+1] == val) begin
                g[r][c+1] = 0; g[r][c] = val + 1; scored(k, val + 1); emit(k);
                fall(c+1, r); emit(k);
            end else begin
                emit(k);
                done = 1'b1;
                if (!bs.won) begin bs.is_spawn = 1'b1; qpush(k, bs); end
            end
        end
    endtask

    task automatic step(input int k);
        snap_t s;
        if (rst) begin
            ex[k] = '{board: '0, score: 0, cur: C/2, spw: 0, busy: 1'b1, over: 1'b0,
                      won: 1'b0, rej: 1'b0, is_spawn: 1'b0};
            if (k == 0) q0.delete(); else q1.delete();
            s = ex[k];
            s.is_spawn = 1'b1;
            qpush(k, s);
        end else if (qsize(k) > 0) begin
            qpop(k, s);
            if (s.is_spawn) begin
                ex[k].spw  = spawn_of(ex[k].board, lf);
                ex[k].cur  = C/2;
                ex[k].busy = 1'b0;
                ex[k].rej  = 1'b0;
            end else ex[k] = s;
        end else if (!ex[k].busy) begin
            ex[k].rej = 1'b0;
            if (cmd_drop) begin ex[k].busy = 1'b1; build(k); end
            else if (cmd_left && !cmd_right) begin if (ex[k].cur > 0) ex[k].cur--; end
            else if (cmd_right && !cmd_left) begin if (ex[k].cur < C-1) ex[k].cur++; end
        end
    endtask

    task automatic chk(input string nm, input int k, input longint act, input longint want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", nm, k, act, want);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            chk("board",  k, longint'(bd[k]),  longint'(ex[k].board));
            chk("score",  k, longint'(sco[k]), longint'(ex[k].score));
            chk("cursor", k, longint'(cur[k]), longint'(ex[k].cur));
            chk("spawn",  k, longint'(spw[k]), longint'(ex[k].spw));
            chk("busy",   k, longint'(bsy[k]), longint'(ex[k].busy));
            chk("over",   k, longint'(ovr[k]), longint'(ex[k].over));
            chk("won",    k, longint'(wn[k]),  longint'(ex[k].won));
            chk("reject", k, longint'(rej[k]), longint'(ex[k].rej));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        step(0);
        step(1);
        lf = rst ? SEED : {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int tc, rv;
        tc = 0;
        lf = SEED;
        repeat (2) cycle();
        chk("rst_board",  0, longint'(bd[0]),  0);
        chk("rst_busy",   0, longint'(bsy[0]), 1);
        chk("rst_spawn",  0, longint'(spw[0]), 0);
        chk("rst_cursor", 0, longint'(cur[0]), 2);
        rst = 1'b0;
        cycle();
        // Seed ACE1 has low bits 001, empty board: base power 1.
        chk("first_spawn",  0, longint'(spw[0]), 1);
        chk("first_busy",   0, longint'(bsy[0]), 0);
        chk("first_cursor", 0, longint'(cur[0]), 2);
        cmd_drop = 1'b1;
        cycle();
        cmd_drop = 1'b0;
        chk("land_busy", 0, longint'(bsy[0]), 1);
        cycle();
        cycle();
        chk("cascade_busy", 0, longint'(bsy[0]), 1);
        cycle();
        chk("drop_done_busy", 0, longint'(bsy[0]), 0);
        chk("drop_cell",      0, longint'(bd[0]),  64'd1 << 42);
        chk("drop_score",     0, longint'(sco[0]), 0);

        for (int n = 0; n < 8000; n++) begin
            rv = int'($urandom_range(0, 9));
            cmd_drop  = (rv < 4);
            cmd_left  = (rv == 4 || rv == 5 || rv == 8) || (rv < 4 && $urandom_range(0, 1) == 1);
            cmd_right = (rv == 6 || rv == 7 || rv == 8) || (rv < 4 && $urandom_range(0, 1) == 1);
            if (ex[0].busy && qsize(0) == 0 && (ex[0].over || ex[0].won)) tc++;
            else tc = 0;
            rst = (tc >= 3) || ($urandom_range(0, 399) == 0);
            cycle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
